// File: rtl/regfile_wr_sched_pkg.sv
// Shared definitions for the register-file write scheduler: FSM encodings,
// default widths and register count.
package regfile_wr_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } wr_state_e;

  localparam int unsigned DEFAULT_NUM_REQ = 3;
  localparam int unsigned DEFAULT_DATA_W  = 32;
  localparam int unsigned DEFAULT_ADDR_W  = 5;
  localparam int unsigned REG_COUNT       = 2 ** DEFAULT_ADDR_W;

  function automatic int unsigned reg_count(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// NUM_REQ-way round-robin arbiter: the search starts at ptr_i and wraps, and the
// first valid source found gets a one-hot grant.
module regfile_wr_sched_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!found && valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        found         = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: round-robin writeback arbitration
// plus a zero-sweep of every register. Optional macro: REGFILE_WR_R0_DROP_EN.
module regfile_wr_sched
  import regfile_wr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       clear_req,
  output logic                       RW,
  output logic [ADDR_W-1:0]          Dsel,
  output logic [DATA_W-1:0]          DIN,
  output logic                       busy,
  output logic [2:0]                 grant_idx
);

  localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RegCount = reg_count(ADDR_W);
  localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(RegCount - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] dsel_q, dsel_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [2:0]        grant_idx_q, grant_idx_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_any;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  regfile_wr_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign win_addr = req_addr[32'(arb_idx) * ADDR_W +: ADDR_W];
  assign win_data = req_data[32'(arb_idx) * DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rw_d        = 1'b0;
    dsel_d      = dsel_q;
    din_d       = din_q;
    grant_idx_d = grant_idx_q;
    req_ready   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          // The first sweep write is issued on the same edge that enters CLEAR.
          state_d     = ST_CLEAR;
          sweep_cnt_d = '0;
          rw_d        = 1'b1;
          dsel_d      = '0;
          din_d       = '0;
        end else if (arb_any) begin
          req_ready   = arb_grant;
          rr_ptr_d    = IdxW'((32'(arb_idx) + 32'd1) % NUM_REQ);
          grant_idx_d = 3'(arb_idx);
`ifdef REGFILE_WR_R0_DROP_EN
          // R0 is hard-wired zero: accept the request but suppress the write.
          if (win_addr != '0) begin
            rw_d   = 1'b1;
            dsel_d = win_addr;
            din_d  = win_data;
          end
`else
          rw_d   = 1'b1;
          dsel_d = win_addr;
          din_d  = win_data;
`endif
        end
      end
      ST_CLEAR: begin
        if (sweep_cnt_q == LastReg) begin
          state_d     = ST_IDLE;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
          rw_d        = 1'b1;
          dsel_d      = sweep_cnt_q + 1'b1;
          din_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sweep_cnt_q <= '0;
      rr_ptr_q    <= '0;
      rw_q        <= 1'b0;
      dsel_q      <= '0;
      din_q       <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rw_q        <= rw_d;
      dsel_q      <= dsel_d;
      din_q       <= din_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign RW        = rw_q;
  assign Dsel      = dsel_q;
  assign DIN       = din_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: a behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_wr_sched;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              clear_req;
  logic              RW;
  logic [AW-1:0]     Dsel;
  logic [DW-1:0]     DIN;
  logic              busy;
  logic [2:0]        grant_idx;

  int n_cmp = 0;
  int n_err = 0;
  bit run   = 1'b0;

  regfile_wr_sched #(
    .NUM_REQ (NREQ),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .clear_req (clear_req),
    .RW        (RW),
    .Dsel      (Dsel),
    .DIN       (DIN),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sweep index shown on the port (-1 when not sweeping), rr pointer, outputs.
  int          m_idx;
  int          m_ptr;
  logic        m_rw;
  logic [31:0] m_dsel;
  logic [31:0] m_din;
  logic [31:0] m_gidx;

  function automatic int model_winner();
    for (int off = 0; off < NREQ; off++)
      if (req_valid[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    int w;
    r = '0;
    w = model_winner();
    if (m_idx < 0 && !clear_req && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_idx  <= -1;
      m_ptr  <= 0;
      m_rw   <= 1'b0;
      m_dsel <= '0;
      m_din  <= '0;
      m_gidx <= '0;
    end else if (m_idx >= 0) begin
      if (m_idx == NREG - 1) begin
        m_idx <= -1;
        m_rw  <= 1'b0;
      end else begin
        m_idx  <= m_idx + 1;
        m_rw   <= 1'b1;
        m_dsel <= 32'(m_idx + 1);
        m_din  <= '0;
      end
    end else if (clear_req) begin
      m_idx  <= 0;
      m_rw   <= 1'b1;
      m_dsel <= '0;
      m_din  <= '0;
    end else if (model_winner() >= 0) begin
      m_gidx <= 32'(model_winner());
      m_ptr  <= (model_winner() + 1) % NREQ;
`ifdef REGFILE_WR_R0_DROP_EN
      if (req_addr[model_winner()*AW +: AW] != '0) begin
        m_rw   <= 1'b1;
        m_dsel <= 32'(req_addr[model_winner()*AW +: AW]);
        m_din  <= req_data[model_winner()*DW +: DW];
      end else begin
        m_rw <= 1'b0;
      end
`else
      m_rw   <= 1'b1;
      m_dsel <= 32'(req_addr[model_winner()*AW +: AW]);
      m_din  <= req_data[model_winner()*DW +: DW];
`endif
    end else begin
      m_rw <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (run && !reset) begin
      check("model_rw", 32'(RW), 32'(m_rw));
      check("model_dsel", 32'(Dsel), m_dsel);
      check("model_din", DIN, m_din);
      check("model_busy", 32'(busy), 32'(m_idx >= 0));
      check("model_gidx", 32'(grant_idx), m_gidx);
      check("model_ready", 32'(req_ready), 32'(model_ready()));
    end
  end

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clear_req = 1'b0;
    do_reset();

    // Reset values
    check("rst_rw", 32'(RW), 32'd0);
    check("rst_dsel", 32'(Dsel), 32'd0);
    check("rst_din", DIN, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gidx", 32'(grant_idx), 32'd0);

    // 1: single source
    set_src(0, 5'd7, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    #1 check("t1_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = '0;
    check("t1_rw", 32'(RW), 32'd1);
    check("t1_dsel", 32'(Dsel), 32'd7);
    check("t1_din", DIN, 32'hDEAD_BEEF);
    step();
    check("t1_rw_idle", 32'(RW), 32'd0);
    check("t1_dsel_hold", 32'(Dsel), 32'd7);

    // 2: all sources continuously valid, pointer starting at 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, AW'(i + 1), 32'hA0 + 32'(i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t2_gidx", 32'(grant_idx), 32'(k % 3));
      check("t2_rw", 32'(RW), 32'd1);
      check("t2_dsel", 32'(Dsel), 32'(k % 3 + 1));
      check("t2_din", DIN, 32'hA0 + 32'(k % 3));
    end
    req_valid = '0;
    step();

    // 3: clear sweep, with a second clear_req mid-sweep that must be ignored
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    req_valid = 3'b100;
    for (int k = 0; k < NREG; k++) begin
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_rw", 32'(RW), 32'd1);
      check("t3_dsel", 32'(Dsel), 32'(k));
      check("t3_din", DIN, 32'd0);
      check("t3_ready", 32'(req_ready), 32'd0);
      clear_req = (k == 5);
      step();
    end
    check("t3_post_busy", 32'(busy), 32'd0);
    check("t3_post_rw", 32'(RW), 32'd0);
    check("t3_post_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = '0;
    check("t3_grant_rw", 32'(RW), 32'd1);
    check("t3_grant_dsel", 32'(Dsel), 32'd3);
    check("t3_grant_gidx", 32'(grant_idx), 32'd2);

    // 4: clear and a valid request in the same cycle
    set_src(1, 5'd2, 32'hB1);
    clear_req = 1'b1;
    req_valid = 3'b010;
    #1 check("t4_ready_clr", 32'(req_ready), 32'd0);
    step();
    clear_req = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    n = 0;
    while (!req_ready[1] && n < 40) begin
      step();
      n++;
    end
    check("t4_wait_cycles", 32'(n), 32'd32);
    step();
    req_valid = '0;
    check("t4_rw", 32'(RW), 32'd1);
    check("t4_dsel", 32'(Dsel), 32'd2);
    check("t4_gidx", 32'(grant_idx), 32'd1);

    // 5: reset in the middle of a sweep
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("t5_dsel10", 32'(Dsel), 32'd10);
    #1 reset = 1'b1;
    #1;
    check("t5_rw", 32'(RW), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_dsel", 32'(Dsel), 32'd0);
    step();
    reset = 1'b0;
    set_src(0, 5'd9, 32'h1234_5678);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    check("t5_rw_after", 32'(RW), 32'd1);
    check("t5_dsel_after", 32'(Dsel), 32'd9);
    check("t5_din_after", DIN, 32'h1234_5678);

    // 6: write to register 0
    set_src(2, 5'd0, 32'h55);
    req_valid = 3'b100;
    #1 check("t6_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = '0;
`ifdef REGFILE_WR_R0_DROP_EN
    check("t6_rw_drop", 32'(RW), 32'd0);
`else
    check("t6_rw", 32'(RW), 32'd1);
    check("t6_dsel", 32'(Dsel), 32'd0);
    check("t6_din", DIN, 32'h55);
`endif

    // Same-address writes serialize in grant order; the last grant lands last
    set_src(0, 5'd4, 32'hC0);
    set_src(1, 5'd4, 32'hC1);
    req_valid = 3'b011;
    step();
    check("t7_first_din", DIN, 32'hC0);
    req_valid = 3'b010;
    step();
    req_valid = '0;
    check("t7_dsel", 32'(Dsel), 32'd4);
    check("t7_last_din", DIN, 32'hC1);
    check("t7_gidx", 32'(grant_idx), 32'd1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
